vga_sync_sequencer: RTL

//  Sequences the VGA horizontal and vertical sync timing.

---
 rtl/vga_sync_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vga_sync_sequencer.sv
// VGA horizontal/vertical sync sequencer: pixel counters, phase FSMs,
// one-clock set/reset strobes for external sync flops, and mirrored sync levels.
module vga_sync_sequencer #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             tick,
    output logic             hs_s,
    output logic             hs_r,
    output logic             vs_s,
    output logic             vs_r,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_FRONT_AT = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_AT  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_BACK_AT  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FRONT_AT = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_SYNC_AT  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_BACK_AT  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_VISIBLE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_last_c;
    logic             v_last_c;
    logic [CNT_W-1:0] h_next_c;
    logic [CNT_W-1:0] v_next_c;

    // Next counter values; vertical advances only on the horizontal wrap.
    always_comb begin
        h_last_c = (pixel_x == H_LAST);
        v_last_c = (pixel_y == V_LAST);
        h_next_c = h_last_c ? '0 : pixel_x + CNT_W'(1);
        v_next_c = pixel_y;
        if (h_last_c) begin
            v_next_c = v_last_c ? '0 : pixel_y + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            h_phase     <= PH_VISIBLE;
            v_phase     <= PH_VISIBLE;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            hs_s        <= 1'b0;
            hs_r        <= 1'b0;
            vs_s        <= 1'b0;
            vs_r        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs_s        <= 1'b0;
            hs_r        <= 1'b0;
            vs_s        <= 1'b0;
            vs_r        <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                pixel_x     <= h_next_c;
                pixel_y     <= v_next_c;
                frame_start <= h_last_c && v_last_c;
                video_on    <= (h_next_c < H_FRONT_AT) && (v_next_c < V_FRONT_AT);

                case (h_phase)
                    PH_VISIBLE: if (h_next_c == H_FRONT_AT) h_phase <= PH_FRONT;
                    PH_FRONT: if (h_next_c == H_SYNC_AT) begin
                        h_phase <= PH_SYNC;
                        hsync   <= 1'b0;
                        hs_r    <= 1'b1;
                    end
                    PH_SYNC: if (h_next_c == H_BACK_AT) begin
                        h_phase <= PH_BACK;
                        hsync   <= 1'b1;
                        hs_s    <= 1'b1;
                    end
                    PH_BACK: if (h_next_c == '0) h_phase <= PH_VISIBLE;
                endcase

                // Vertical phase moves once per line, on the horizontal wrap edge.
                if (h_last_c) begin
                    case (v_phase)
                        PH_VISIBLE: if (v_next_c == V_FRONT_AT) v_phase <= PH_FRONT;
                        PH_FRONT: if (v_next_c == V_SYNC_AT) begin
                            v_phase <= PH_SYNC;
                            vsync   <= 1'b0;
                            vs_r    <= 1'b1;
                        end
                        PH_SYNC: if (v_next_c == V_BACK_AT) begin
                            v_phase <= PH_BACK;
                            vsync   <= 1'b1;
                            vs_s    <= 1'b1;
                        end
                        PH_BACK: if (v_next_c == '0) v_phase <= PH_VISIBLE;
                    endcase
                end
            end
        end
    end

endmodule
